if_id_buffer: RTL and testbench

- Decoupling instruction queue between the fetch stage and the decode stage of the pipelined ARM core.
- Captures each fetched {PC, Instruction} pair and presents the pairs in order to decode, using a valid/ready handshake.
- Backpressure to fetch comes out as in_ready; the core drives the fetch Freeze input from ~in_ready.
- A branch flush empties the queue in a single cycle, so no wrong-path instruction reaches decode.

---
 rtl/if_id_buffer.sv | 93 +++++++++
 tb/tb_if_id_buffer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/if_id_buffer.sv
// if_id_buffer: in-order {PC, Instruction} queue between fetch and decode.
// Valid/ready handshake on both sides. Flush empties the queue in one cycle.
// The head entry is read combinationally. An empty queue presents zeros (NOP).
// Optional macro IF_ID_BYPASS_EN: when the queue is empty and decode is ready,
// the incoming pair goes straight to the outputs in the same cycle and is not stored.
module if_id_buffer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       Flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           PC_in,
  input  logic [WIDTH-1:0]           Instruction_in,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           PC_out,
  output logic [WIDTH-1:0]           Instruction_out,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] pc_mem   [DEPTH];
  logic [WIDTH-1:0] inst_mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             not_empty;
  logic             bypass;
  logic             push;
  logic             pop;

  // Handshake qualifiers; Flush overrides both queue operations.
  always_comb begin
    not_empty = (count != '0);
`ifdef IF_ID_BYPASS_EN
    bypass    = ~not_empty & in_valid & out_ready & ~Flush;
`else
    bypass    = 1'b0;
`endif
    in_ready  = (count != FULL_CNT);
    out_valid = not_empty | bypass;
    push      = in_valid & in_ready & ~Flush & ~bypass;
    pop       = not_empty & out_ready & ~Flush;
  end

  // Head outputs: stored entry, bypassed input, or NOP when nothing is valid.
  always_comb begin
    PC_out          = '0;
    Instruction_out = '0;
    if (not_empty) begin
      PC_out          = pc_mem[rd_ptr];
      Instruction_out = inst_mem[rd_ptr];
    end else if (bypass) begin
      PC_out          = PC_in;
      Instruction_out = Instruction_in;
    end
  end

  // Pointer and occupancy tracking; flush returns everything to the empty state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; validity is tracked by count, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= PC_in;
      inst_mem[wr_ptr] <= Instruction_in;
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed testbench for if_id_buffer (DEPTH=4, WIDTH=32).
module tb_if_id_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        Flush;
  logic        in_valid;
  logic [31:0] PC_in;
  logic [31:0] Instruction_in;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] PC_out;
  logic [31:0] Instruction_out;
  logic [2:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  if_id_buffer #(.DEPTH(4), .WIDTH(32)) dut (
    .clk(clk), .reset(reset), .Flush(Flush), .in_valid(in_valid),
    .PC_in(PC_in), .Instruction_in(Instruction_in), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .PC_out(PC_out),
    .Instruction_out(Instruction_out), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    in_valid       = v;
    PC_in          = pc;
    Instruction_in = inst;
  endtask

  initial begin
    reset = 1'b0; Flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 32'd4, 32'hE3A01005);

    // Reset held with in_valid asserted
    tick(); tick();
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_pc", PC_out, 32'd0);
    check("rst_inst", Instruction_out, 32'd0);

    // Release reset between edges, then first push
    #2 reset = 1'b1;
    tick();
    drive(1'b0, 32'd0, 32'd0);
    check("first_valid", 32'(out_valid), 32'd1);
    check("first_pc", PC_out, 32'd4);
    check("first_inst", Instruction_out, 32'hE3A01005);
    check("first_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("first_drained", 32'(count), 32'd0);

    // Fill to full with out_ready low; fifth pair must be refused
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 32'(4 * i), 32'h1000 + 32'(4 * i));
      #1;
      if (i == 5) check("full_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    drive(1'b0, 32'd0, 32'd0);
    check("full_count", 32'(count), 32'd4);
    tick();
    check("hold_pc", PC_out, 32'd4);
    check("hold_count", 32'(count), 32'd4);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_pc", PC_out, 32'(4 * i));
      check("drain_inst", Instruction_out, 32'h1000 + 32'(4 * i));
      tick();
    end
    check("drain_empty_valid", 32'(out_valid), 32'd0);
    check("drain_empty_count", 32'(count), 32'd0);

    // Wrap-around: prime one entry, then 10 cycles of simultaneous push/pop
    out_ready = 1'b0;
    drive(1'b1, 32'd100, 32'hA100);
    tick();
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 32'd100 + 32'(4 * i), 32'hA100 + 32'(4 * i));
      #1;
      check("wrap_pc", PC_out, 32'd100 + 32'(4 * (i - 1)));
      check("wrap_inst", Instruction_out, 32'hA100 + 32'(4 * (i - 1)));
      tick();
      check("wrap_count", 32'(count), 32'd1);
    end
    drive(1'b0, 32'd0, 32'd0);
    check("wrap_last_pc", PC_out, 32'd140);
    tick();
    check("wrap_drained", 32'(count), 32'd0);

    // Flush with 3 stored entries plus concurrent push and pop
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'd200 + 32'(4 * i), 32'hF200 + 32'(4 * i));
      tick();
    end
    check("pre_flush_count", 32'(count), 32'd3);
    Flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'd212, 32'hF212);
    tick();
    Flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    check("flush_count", 32'(count), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_pc", PC_out, 32'd0);
    drive(1'b1, 32'd300, 32'hC300);
    tick();
    drive(1'b0, 32'd0, 32'd0);
    check("post_flush_pc", PC_out, 32'd300);
    check("post_flush_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Asynchronous reset with two entries stored
    drive(1'b1, 32'd400, 32'hD400); tick();
    drive(1'b1, 32'd404, 32'hD404); tick();
    drive(1'b0, 32'd0, 32'd0);
    check("pre_arst_count", 32'(count), 32'd2);
    #2 reset = 1'b0;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    #2 reset = 1'b1;
    tick(); tick();
    check("post_arst_valid", 32'(out_valid), 32'd0);
    check("post_arst_pc", PC_out, 32'd0);

    // Empty queue with decode ready: bypass or not depending on build
    out_ready = 1'b1;
    drive(1'b1, 32'h40, 32'hE1A00000);
    #1;
`ifdef IF_ID_BYPASS_EN
    check("byp_out_valid", 32'(out_valid), 32'd1);
    check("byp_pc", PC_out, 32'h40);
    check("byp_inst", Instruction_out, 32'hE1A00000);
    tick();
    drive(1'b0, 32'd0, 32'd0);
    check("byp_count", 32'(count), 32'd0);
`else
    check("nobyp_out_valid", 32'(out_valid), 32'd0);
    check("nobyp_pc", PC_out, 32'd0);
    tick();
    drive(1'b0, 32'd0, 32'd0);
    check("nobyp_count", 32'(count), 32'd1);
    check("nobyp_next_pc", PC_out, 32'h40);
    tick();
    check("nobyp_drained", 32'(count), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
